// File: rtl/pwm_bridge_pkg.sv
// Shared definitions for the half-bridge PWM controller.
//   bridge_state_t : dead-band FSM state encoding
//   *_DEF          : default CNT_W / DEAD_W / DEAD_RST values
package pwm_bridge_pkg;

    localparam int CNT_W_DEF    = 11;
    localparam int DEAD_W_DEF   = 6;
    localparam int DEAD_RST_DEF = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DEAD_H = 3'd1,
        HIGH   = 3'd2,
        DEAD_L = 3'd3,
        LOW    = 3'd4,
        FAULT  = 3'd5
    } bridge_state_t;

endpackage

// File: rtl/pwm_bridge_ctrl_if.sv
// Control-loop / gate-drive side signals of pwm_bridge_ctrl.
//   master : control side (drives en, duty, dead, fault strobes; observes gates)
//   slave  : the controller itself
//   en, duty, duty_vld, dead, dead_wr, fault, fault_clr : control inputs
//   PWM_high, PWM_low, period_strt, faulted             : status / gate outputs
interface pwm_bridge_ctrl_if
    import pwm_bridge_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DEAD_W = DEAD_W_DEF
);
    logic              en;
    logic [CNT_W-1:0]  duty;
    logic              duty_vld;
    logic [DEAD_W-1:0] dead;
    logic              dead_wr;
    logic              fault;
    logic              fault_clr;
    logic              PWM_high;
    logic              PWM_low;
    logic              period_strt;
    logic              faulted;

    modport master (
        output en, duty, duty_vld, dead, dead_wr, fault, fault_clr,
        input  PWM_high, PWM_low, period_strt, faulted
    );

    modport slave (
        input  en, duty, duty_vld, dead, dead_wr, fault, fault_clr,
        output PWM_high, PWM_low, period_strt, faulted
    );

endinterface

// File: rtl/dead_band_fsm.sv
// Dead-band inserter and fault latch for one half-bridge phase.
//
//   state  | meaning
//   -------+-----------------------------------------------
//   IDLE   | disabled, both gates off
//   DEAD_H | dead time before high-side turn-on
//   HIGH   | high-side gate on
//   DEAD_L | dead time before low-side turn-on
//   LOW    | low-side gate on
//   FAULT  | latched fault, both gates off until cleared
//
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   raw               : undelayed PWM (cnt < duty_act)
//   en                : run enable
//   fault, fault_clr  : fault input, clear strobe
//   dead_reg          : programmed dead time (0 treated as 1)
//   PWM_high, PWM_low : registered gate enables
//   faulted           : registered, high while in FAULT
module dead_band_fsm
    import pwm_bridge_pkg::*;
#(
    parameter int DEAD_W = DEAD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              raw,
    input  logic              en,
    input  logic              fault,
    input  logic              fault_clr,
    input  logic [DEAD_W-1:0] dead_reg,
    output logic              PWM_high,
    output logic              PWM_low,
    output logic              faulted
);

    bridge_state_t     state;
    bridge_state_t     state_nxt;
    logic [DEAD_W-1:0] dcnt;
    logic [DEAD_W-1:0] dlim;
    logic [DEAD_W-1:0] dlim_new;
    logic              dead_entry;
    logic              high_nxt;
    logic              low_nxt;
    logic              faulted_nxt;

    // Terminal count is D-1 with D = max(dead_reg,1); snapshot on entry so a
    // dead_reg write never stretches or truncates a gap already in progress.
    assign dlim_new   = (dead_reg == '0) ? '0 : dead_reg - DEAD_W'(1);
    assign dead_entry = ((state_nxt == DEAD_H) || (state_nxt == DEAD_L)) &&
                        (state_nxt != state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dcnt     <= '0;
            dlim     <= '0;
            PWM_high <= 1'b0;
            PWM_low  <= 1'b0;
            faulted  <= 1'b0;
        end else begin
            state    <= state_nxt;
            PWM_high <= high_nxt;
            PWM_low  <= low_nxt;
            faulted  <= faulted_nxt;
            if (dead_entry) begin
                dcnt <= '0;
                dlim <= dlim_new;
            end else if ((state == DEAD_H) || (state == DEAD_L)) begin
                dcnt <= dcnt + DEAD_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (fault) begin
            state_nxt = FAULT;
        end else if (state == FAULT) begin
            if (fault_clr) state_nxt = IDLE;
        end else if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = raw ? DEAD_H : DEAD_L;
                DEAD_H: begin
                    if (!raw)              state_nxt = DEAD_L;
                    else if (dcnt == dlim) state_nxt = HIGH;
                end
                HIGH:    if (!raw) state_nxt = DEAD_L;
                DEAD_L: begin
                    if (raw)               state_nxt = DEAD_H;
                    else if (dcnt == dlim) state_nxt = LOW;
                end
                LOW:     if (raw) state_nxt = DEAD_H;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are flops loaded from the next-state decode, so they track the
    // state register exactly and never glitch on a multi-bit state change.
    always_comb begin
        high_nxt    = (state_nxt == HIGH);
        low_nxt     = (state_nxt == LOW);
        faulted_nxt = (state_nxt == FAULT);
    end

endmodule

// File: rtl/pwm_bridge_ctrl.sv
// Half-bridge PWM controller top: period counter, double-buffered duty,
// dead-time register and period-start pulse; dead-band FSM in dead_band_fsm.
// Ports:
//   clk   : system clock
//   rst_n : async active-low reset
//   bus   : pwm_bridge_ctrl_if.slave (control inputs, gate/status outputs)
module pwm_bridge_ctrl
    import pwm_bridge_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEAD_W   = DEAD_W_DEF,
    parameter int DEAD_RST = DEAD_RST_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    pwm_bridge_ctrl_if.slave    bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  duty_pend;
    logic [CNT_W-1:0]  duty_act;
    logic [DEAD_W-1:0] dead_reg;
    logic              raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt <= '0;
        else if (!bus.en) cnt <= '0;
        else              cnt <= cnt + CNT_W'(1);
    end

    // duty_act only changes on the last count of a period; a strobe on that
    // same cycle lands in duty_pend and waits for the following wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_pend <= '0;
            duty_act  <= '0;
        end else begin
            if (cnt == CNT_MAX) duty_act  <= duty_pend;
            if (bus.duty_vld)   duty_pend <= bus.duty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           dead_reg <= DEAD_W'(DEAD_RST);
        else if (bus.dead_wr) dead_reg <= bus.dead;
    end

    assign raw             = (cnt < duty_act);
    assign bus.period_strt = bus.en && (cnt == '0);

    dead_band_fsm #(
        .DEAD_W (DEAD_W)
    ) u_dead_band_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw       (raw),
        .en        (bus.en),
        .fault     (bus.fault),
        .fault_clr (bus.fault_clr),
        .dead_reg  (dead_reg),
        .PWM_high  (bus.PWM_high),
        .PWM_low   (bus.PWM_low),
        .faulted   (bus.faulted)
    );

endmodule
